fht_but_array: RTL and testbench
================================

Name: fht_but_array

Overview:
- Parametrised array of NUM_BUT radix-2 Hartley butterflies for the FHT datapath.
- Each butterfly combines a direct point X0 with the twiddled pair X1, X2: Y0 = X0 + T and Y1 = X0 − T, where T = X1·cos + X2·sin.
- Adds valid-tagged pipelining, per-stage /2 scaling, saturation with sticky overflow flags, and a selectable output ordering.
- Sits between the bank read mixers and the bank write path. Replaces the fixed two-butterfly block.

Parameters:
- D_BIT, 17, signed data width of all points.
- W_BIT, 12, signed twiddle width. 1.0 is represented as W_ONE = 2^(W_BIT-2).
- NUM_BUT, 2, number of butterflies. Must be a power of 2, from 1 to 8.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  reset, asynchronous, active-low.
- iVALID  in  1  input lane data valid this cycle.
- iSCALE  in  1  when 1, halve both butterfly outputs (stage scaling).
- iMIX_MODE  in  2  output ordering select.
- iCLR_OVF  in  1  synchronous clear of oOVF.
- iX0  in  NUM_BUT*D_BIT  direct points; lane k occupies bits [k*D_BIT +: D_BIT].
- iX1  in  NUM_BUT*D_BIT  cos-multiplied points.
- iX2  in  NUM_BUT*D_BIT  sin-multiplied points.
- iCOS  in  NUM_BUT*W_BIT  per-lane cosine.
- iSIN  in  NUM_BUT*W_BIT  per-lane sine.
- oVALID  out  1  oY holds a new result.
- oY  out  2*NUM_BUT*D_BIT  output points; slot j occupies bits [j*D_BIT +: D_BIT].
- oOVF  out  NUM_BUT  sticky per-butterfly saturation flag.

Behaviour:
- Reset: all pipeline registers, oY, oVALID and oOVF are 0. Reset asserted mid-stream discards all in-flight data; oVALID stays 0 until a new iVALID has propagated.
- Pipeline is fixed at 3 cycles with no backpressure. iVALID sampled at edge n produces oVALID = 1 for exactly one cycle after edge n+3. Back-to-back iVALID yields back-to-back oVALID.
- S1 registers the data, twiddles, iSCALE and iMIX_MODE. The control fields travel with the data, so mode and scale may change every cycle.
- S2 registers per-lane products P1 = X1·cos and P2 = X2·sin, each full width D_BIT+W_BIT. X0 is delayed alongside.
- S3 arithmetic, per lane:
  - P = P1 + P2, width D_BIT+W_BIT+1.
  - T = (P + 2^(W_BIT-3)) >>> (W_BIT-2). This rounds half up.
  - A = X0 + T and B = X0 − T, computed at D_BIT+2 bits.
  - If scale is set: A = A >>> 1 and B = B >>> 1 (arithmetic shift, truncation).
  - A and B are then saturated to the range [−2^(D_BIT-1), 2^(D_BIT-1)−1].
- oY updates only when the S3 valid bit is set; otherwise it holds its previous value.
- Output ordering, with Y0k/Y1k the results of lane k:
  - Mode 0 (natural): slot 2k = Y0k, slot 2k+1 = Y1k.
  - Mode 1 (split): slot k = Y0k, slot NUM_BUT+k = Y1k.
  - Mode 2 (swap): slot 2k = Y1k, slot 2k+1 = Y0k.
  - Mode 3 is reserved and behaves as mode 0.
- oOVF[k] is set on the valid S3 cycle when A or B of lane k exceeds the range. It holds until iCLR_OVF.
- If iCLR_OVF and a new overflow occur in the same cycle, set wins.
- Overflow detection happens after scaling, so a scaled result that fits never flags.
- Inputs are only sampled when iVALID = 1. Non-valid cycles never touch oY or oOVF.

Optional Feature:
- Macro: FHT_BUT_SAT_EN.
- Defined: saturation as described above.
- Undefined: A and B wrap by truncation to D_BIT bits (two's complement). oOVF detection and clearing are unchanged, so overflow is still reported.

Test Plan (D_BIT=17, W_BIT=12, W_ONE=1024, NUM_BUT=2, FHT_BUT_SAT_EN defined):
1. Lane 0: X0=100, X1=200, X2=0, cos=1024, sin=0, mode 0; one iVALID pulse -> exactly 3 cycles later a single oVALID pulse, slot0=300, slot1=−100, oOVF=0.
2. Rounding: X0=0, X1=3, cos=512, X2=0 -> T=(1536+512)>>>10=2, so Y0=2, Y1=−2. With X1=−3 -> T=−1, so Y0=−1, Y1=1.
3. Saturation: X0=65535, X1=1024, cos=1024:
   - scale=0 -> Y0=65535 (saturated), Y1=64511, oOVF[0]=1 and holding.
   - Repeat with scale=1 -> Y0=33279, Y1=32255, no new flag.
   - Pulse iCLR_OVF -> oOVF=0.
4. Mix modes: lane0 gives (Y0,Y1)=(1,2), lane1 gives (3,4).
   - Mode 1 -> slots 0..3 = 1,3,2,4.
   - Mode 2 -> 2,1,4,3.
   - Mode 3 -> 1,2,3,4.
   - Mode changed on consecutive valid cycles -> each result uses its own mode.
5. Streaming: 8 consecutive valids with X0=0..7 (T=0) -> 8 consecutive oVALID with matching slot0 values; iVALID gaps are reproduced 3 cycles later; oY holds during gaps.
6. Reset and clear:
   - Assert iRESET with 2 results in flight -> oVALID never pulses for them; oY=0, oOVF=0.
   - iCLR_OVF coinciding with a fresh overflow -> oOVF stays 1.

Source files
------------

// File: rtl/fht_but_array.sv
// Array of NUM_BUT radix-2 Hartley butterflies with a 3-cycle valid-tagged pipeline.
// Define FHT_BUT_SAT_EN to saturate outputs; otherwise they wrap (overflow is flagged either way).
module fht_but_array #(
  parameter int D_BIT   = 17,
  parameter int W_BIT   = 12,
  parameter int NUM_BUT = 2
) (
  input  logic                         iCLK,
  input  logic                         iRESET,
  input  logic                         iVALID,
  input  logic                         iSCALE,
  input  logic [1:0]                   iMIX_MODE,
  input  logic                         iCLR_OVF,
  input  logic [NUM_BUT*D_BIT-1:0]     iX0,
  input  logic [NUM_BUT*D_BIT-1:0]     iX1,
  input  logic [NUM_BUT*D_BIT-1:0]     iX2,
  input  logic [NUM_BUT*W_BIT-1:0]     iCOS,
  input  logic [NUM_BUT*W_BIT-1:0]     iSIN,
  output logic                         oVALID,
  output logic [2*NUM_BUT*D_BIT-1:0]   oY,
  output logic [NUM_BUT-1:0]           oOVF
);

  localparam int PW = D_BIT + W_BIT;
  localparam int SW = PW + 1;
  localparam int AW = D_BIT + 2;
  localparam logic signed [SW-1:0] RND  = SW'(2 ** (W_BIT - 3));
  localparam logic signed [AW-1:0] SMAX = AW'(2 ** (D_BIT - 1) - 1);
  localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);

  logic                      v1_q, scale1_q;
  logic [1:0]                mode1_q;
  logic signed [D_BIT-1:0]   x0_1_q [NUM_BUT];
  logic signed [D_BIT-1:0]   x1_1_q [NUM_BUT];
  logic signed [D_BIT-1:0]   x2_1_q [NUM_BUT];
  logic signed [W_BIT-1:0]   cos1_q [NUM_BUT];
  logic signed [W_BIT-1:0]   sin1_q [NUM_BUT];

  logic                      v2_q, scale2_q;
  logic [1:0]                mode2_q;
  logic signed [D_BIT-1:0]   x0_2_q [NUM_BUT];
  logic signed [PW-1:0]      p1_q   [NUM_BUT];
  logic signed [PW-1:0]      p2_q   [NUM_BUT];

  logic signed [SW-1:0]      sum_c  [NUM_BUT];
  logic signed [SW-1:0]      t_c    [NUM_BUT];
  logic signed [AW-1:0]      a_c    [NUM_BUT];
  logic signed [AW-1:0]      b_c    [NUM_BUT];
  logic signed [D_BIT-1:0]   y0_d   [NUM_BUT];
  logic signed [D_BIT-1:0]   y1_d   [NUM_BUT];
  logic [NUM_BUT-1:0]        ovf3_d;

  logic                      v3_q;
  logic [1:0]                mode3_q;
  logic signed [D_BIT-1:0]   y0_3_q [NUM_BUT];
  logic signed [D_BIT-1:0]   y1_3_q [NUM_BUT];
  logic [NUM_BUT-1:0]        ovf3_q;

  logic                      valid_q;
  logic [2*NUM_BUT*D_BIT-1:0] y_q, y_d;
  logic [NUM_BUT-1:0]        ovf_q, ovf_d;

  // Control fields travel with the data so mode/scale may change every cycle.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      v1_q     <= 1'b0;
      scale1_q <= 1'b0;
      mode1_q  <= 2'd0;
      for (int k = 0; k < NUM_BUT; k++) begin
        x0_1_q[k] <= '0;
        x1_1_q[k] <= '0;
        x2_1_q[k] <= '0;
        cos1_q[k] <= '0;
        sin1_q[k] <= '0;
      end
    end else begin
      v1_q <= iVALID;
      if (iVALID) begin
        scale1_q <= iSCALE;
        mode1_q  <= iMIX_MODE;
        for (int k = 0; k < NUM_BUT; k++) begin
          x0_1_q[k] <= iX0[k*D_BIT +: D_BIT];
          x1_1_q[k] <= iX1[k*D_BIT +: D_BIT];
          x2_1_q[k] <= iX2[k*D_BIT +: D_BIT];
          cos1_q[k] <= iCOS[k*W_BIT +: W_BIT];
          sin1_q[k] <= iSIN[k*W_BIT +: W_BIT];
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      v2_q     <= 1'b0;
      scale2_q <= 1'b0;
      mode2_q  <= 2'd0;
      for (int k = 0; k < NUM_BUT; k++) begin
        x0_2_q[k] <= '0;
        p1_q[k]   <= '0;
        p2_q[k]   <= '0;
      end
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        scale2_q <= scale1_q;
        mode2_q  <= mode1_q;
        for (int k = 0; k < NUM_BUT; k++) begin
          x0_2_q[k] <= x0_1_q[k];
          p1_q[k]   <= PW'(x1_1_q[k]) * PW'(cos1_q[k]);
          p2_q[k]   <= PW'(x2_1_q[k]) * PW'(sin1_q[k]);
        end
      end
    end
  end

  // Twiddle sum rounded half-up back to data scale, then add/subtract, scale and range-check.
  always_comb begin
    ovf3_d = '0;
    for (int k = 0; k < NUM_BUT; k++) begin
      sum_c[k] = SW'(p1_q[k]) + SW'(p2_q[k]);
      t_c[k]   = (sum_c[k] + RND) >>> (W_BIT - 2);
      a_c[k]   = AW'(x0_2_q[k]) + AW'(t_c[k]);
      b_c[k]   = AW'(x0_2_q[k]) - AW'(t_c[k]);
      if (scale2_q) begin
        a_c[k] = a_c[k] >>> 1;
        b_c[k] = b_c[k] >>> 1;
      end
      ovf3_d[k] = (a_c[k] > SMAX) || (a_c[k] < SMIN) ||
                  (b_c[k] > SMAX) || (b_c[k] < SMIN);
`ifdef FHT_BUT_SAT_EN
      if (a_c[k] > SMAX)      y0_d[k] = SMAX[D_BIT-1:0];
      else if (a_c[k] < SMIN) y0_d[k] = SMIN[D_BIT-1:0];
      else                    y0_d[k] = a_c[k][D_BIT-1:0];
      if (b_c[k] > SMAX)      y1_d[k] = SMAX[D_BIT-1:0];
      else if (b_c[k] < SMIN) y1_d[k] = SMIN[D_BIT-1:0];
      else                    y1_d[k] = b_c[k][D_BIT-1:0];
`else
      y0_d[k] = a_c[k][D_BIT-1:0];
      y1_d[k] = b_c[k][D_BIT-1:0];
`endif
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      v3_q    <= 1'b0;
      mode3_q <= 2'd0;
      ovf3_q  <= '0;
      for (int k = 0; k < NUM_BUT; k++) begin
        y0_3_q[k] <= '0;
        y1_3_q[k] <= '0;
      end
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        mode3_q <= mode2_q;
        ovf3_q  <= ovf3_d;
        for (int k = 0; k < NUM_BUT; k++) begin
          y0_3_q[k] <= y0_d[k];
          y1_3_q[k] <= y1_d[k];
        end
      end
    end
  end

  // Slot ordering; reserved mode 3 falls through to natural order.
  always_comb begin
    y_d = '0;
    for (int k = 0; k < NUM_BUT; k++) begin
      case (mode3_q)
        2'd1: begin
          y_d[k*D_BIT +: D_BIT]             = y0_3_q[k];
          y_d[(NUM_BUT+k)*D_BIT +: D_BIT]   = y1_3_q[k];
        end
        2'd2: begin
          y_d[(2*k)*D_BIT +: D_BIT]         = y1_3_q[k];
          y_d[(2*k+1)*D_BIT +: D_BIT]       = y0_3_q[k];
        end
        default: begin
          y_d[(2*k)*D_BIT +: D_BIT]         = y0_3_q[k];
          y_d[(2*k+1)*D_BIT +: D_BIT]       = y1_3_q[k];
        end
      endcase
    end
    ovf_d = (iCLR_OVF ? '0 : ovf_q) | (v3_q ? ovf3_q : '0);
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      valid_q <= 1'b0;
      y_q     <= '0;
      ovf_q   <= '0;
    end else begin
      valid_q <= v3_q;
      ovf_q   <= ovf_d;
      if (v3_q) y_q <= y_d;
    end
  end

  assign oVALID = valid_q;
  assign oY     = y_q;
  assign oOVF   = ovf_q;

endmodule

// File: tb/tb_fht_but_array.sv
// Self-checking bench for fht_but_array: random and directed stimulus, integer reference model, scoreboard monitor.
// Honours FHT_BUT_SAT_EN the same way as the design (saturate when defined, wrap otherwise).
module tb_fht_but_array;

  localparam int D_BIT = 17;
  localparam int W_BIT = 12;
  localparam int NB    = 2;
  localparam int YW    = 2 * NB * D_BIT;
  localparam int W_ONE = 2 ** (W_BIT - 2);

  logic                    iCLK = 1'b0;
  logic                    iRESET = 1'b0;
  logic                    iVALID = 1'b0;
  logic                    iSCALE = 1'b0;
  logic [1:0]              iMIX_MODE = 2'd0;
  logic                    iCLR_OVF = 1'b0;
  logic [NB*D_BIT-1:0]     iX0 = '0, iX1 = '0, iX2 = '0;
  logic [NB*W_BIT-1:0]     iCOS = '0, iSIN = '0;
  logic                    oVALID;
  logic [YW-1:0]           oY;
  logic [NB-1:0]           oOVF;

  typedef struct {
    logic [YW-1:0] y;
    logic [NB-1:0] ovf;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  logic [YW-1:0] lastY = '0;
  logic [NB-1:0] modelOvf = '0;
  logic          clrS;

  logic signed [D_BIT-1:0] lx0 [NB];
  logic signed [D_BIT-1:0] lx1 [NB];
  logic signed [D_BIT-1:0] lx2 [NB];
  logic signed [W_BIT-1:0] lc  [NB];
  logic signed [W_BIT-1:0] ls  [NB];

  fht_but_array #(.D_BIT(D_BIT), .W_BIT(W_BIT), .NUM_BUT(NB)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID), .iSCALE(iSCALE),
    .iMIX_MODE(iMIX_MODE), .iCLR_OVF(iCLR_OVF),
    .iX0(iX0), .iX1(iX1), .iX2(iX2), .iCOS(iCOS), .iSIN(iSIN),
    .oVALID(oVALID), .oY(oY), .oOVF(oOVF)
  );

  always #5 iCLK = ~iCLK;

  task automatic checkOutput(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: integer butterfly straight from the arithmetic rules.
  function automatic void refLane(input longint x0, x1, x2, c, s, input bit sc,
                                  output longint y0, output longint y1, output bit ov);
    longint p, t, a, b, mx, mn;
    mx = (longint'(1) <<< (D_BIT - 1)) - 1;
    mn = -(longint'(1) <<< (D_BIT - 1));
    p  = x1 * c + x2 * s;
    t  = (p + (longint'(1) <<< (W_BIT - 3))) >>> (W_BIT - 2);
    a  = x0 + t;
    b  = x0 - t;
    if (sc) begin
      a = a >>> 1;
      b = b >>> 1;
    end
    ov = (a > mx) || (a < mn) || (b > mx) || (b < mn);
`ifdef FHT_BUT_SAT_EN
    if (a > mx) a = mx; else if (a < mn) a = mn;
    if (b > mx) b = mx; else if (b < mn) b = mn;
`endif
    y0 = a;
    y1 = b;
  endfunction

  // Drives one cycle of inputs just after a rising edge; valid cycles push their expected result.
  task automatic applyStimulus(input bit v, input bit sc, input logic [1:0] mode, input bit clr);
    exp_t   e;
    longint y0, y1;
    bit     ov;
    int     s0, s1;
    @(posedge iCLK);
    #1;
    iVALID    = v;
    iSCALE    = sc;
    iMIX_MODE = mode;
    iCLR_OVF  = clr;
    for (int k = 0; k < NB; k++) begin
      iX0[k*D_BIT +: D_BIT]  = lx0[k];
      iX1[k*D_BIT +: D_BIT]  = lx1[k];
      iX2[k*D_BIT +: D_BIT]  = lx2[k];
      iCOS[k*W_BIT +: W_BIT] = lc[k];
      iSIN[k*W_BIT +: W_BIT] = ls[k];
    end
    if (v) begin
      e.y   = '0;
      e.ovf = '0;
      e.cyc = cyc;
      for (int k = 0; k < NB; k++) begin
        refLane(longint'(lx0[k]), longint'(lx1[k]), longint'(lx2[k]),
                longint'(lc[k]), longint'(ls[k]), sc, y0, y1, ov);
        e.ovf[k] = ov;
        if (mode == 2'd1)      begin s0 = k;         s1 = NB + k;    end
        else if (mode == 2'd2) begin s0 = 2 * k + 1; s1 = 2 * k;     end
        else                   begin s0 = 2 * k;     s1 = 2 * k + 1; end
        e.y[s0*D_BIT +: D_BIT] = y0[D_BIT-1:0];
        e.y[s1*D_BIT +: D_BIT] = y1[D_BIT-1:0];
      end
      sb.push_back(e);
    end
  endtask

  task automatic setLane(input int k, input int x0, input int x1, input int x2, input int c, input int s);
    lx0[k] = D_BIT'(x0);
    lx1[k] = D_BIT'(x1);
    lx2[k] = D_BIT'(x2);
    lc[k]  = W_BIT'(c);
    ls[k]  = W_BIT'(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  // Monitor: pops on each oVALID; results must appear 4 edges after the issuing drive (3-cycle pipeline).
  initial begin
    exp_t e;
    forever begin
      @(posedge iCLK);
      cyc++;
      clrS = iCLR_OVF;
      @(negedge iCLK);
      if (!iRESET) begin
        sb.delete();
        lastY    = '0;
        modelOvf = '0;
        checkOutput("reset_valid", YW'(oVALID), '0);
        checkOutput("reset_y", oY, '0);
        checkOutput("reset_ovf", YW'(oOVF), '0);
      end else begin
        if (oVALID) begin
          if (sb.size() == 0) begin
            checkOutput("spurious_valid", YW'(oVALID), '0);
          end else begin
            e = sb.pop_front();
            checkOutput("latency", YW'(cyc - e.cyc), YW'(4));
            checkOutput("y", oY, e.y);
            lastY    = e.y;
            modelOvf = (clrS ? '0 : modelOvf) | e.ovf;
          end
        end else begin
          if (clrS) modelOvf = '0;
          checkOutput("y_hold", oY, lastY);
        end
        checkOutput("ovf", YW'(oOVF), YW'(modelOvf));
      end
    end
  end

  initial begin
    #2_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int waitCnt;
    logic [D_BIT-1:0] r;
    for (int k = 0; k < NB; k++) setLane(k, 0, 0, 0, 0, 0);
    repeat (3) @(posedge iCLK);
    #1 iRESET = 1'b1;
    idle(2);

    $display("[TB] basic butterfly");
    setLane(0, 100, 200, 0, W_ONE, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    setLane(0, 0, 0, 0, 0, 0);
    idle(5);

    $display("[TB] rounding");
    setLane(0, 0, 3, 0, 512, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    setLane(0, 0, -3, 0, 512, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    idle(4);

    $display("[TB] saturation and clear");
    setLane(0, 65535, 1024, 0, W_ONE, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    idle(5);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0);
    idle(5);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    idle(3);

    $display("[TB] mix modes");
    setLane(0, 3, -1, 0, W_ONE, 0);
    setLane(1, 7, -1, 0, W_ONE, 0);
    applyStimulus(1'b1, 1'b1, 2'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd2, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0);
    idle(5);

    $display("[TB] streaming with gaps");
    for (int i = 0; i < 8; i++) begin
      setLane(0, i, 0, 0, 0, 0);
      setLane(1, 0, 0, 0, 0, 0);
      applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    end
    for (int i = 0; i < 7; i++) begin
      setLane(0, 20 + i, 0, 0, 0, 0);
      applyStimulus((i % 3) != 1, 1'b0, 2'd0, 1'b0);
    end
    idle(5);

    $display("[TB] reset with results in flight");
    setLane(0, 65535, 1024, 0, W_ONE, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd1, 1'b0);
    @(posedge iCLK);
    #1 iRESET = 1'b0;
    iVALID = 1'b0;
    repeat (6) @(posedge iCLK);
    #1 iRESET = 1'b1;
    idle(2);

    $display("[TB] clear coinciding with new overflow");
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    idle(5);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    idle(3);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    idle(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NB; k++) begin
        r = D_BIT'($urandom); lx0[k] = r;
        r = D_BIT'($urandom); lx1[k] = r;
        r = D_BIT'($urandom); lx2[k] = r;
        lc[k] = W_BIT'(int'($urandom_range(2 * W_ONE, 0)) - W_ONE);
        ls[k] = W_BIT'(int'($urandom_range(2 * W_ONE, 0)) - W_ONE);
        if ($urandom_range(3, 0) == 0) lx0[k] = D_BIT'(int'($urandom_range(200, 0)) - 100);
      end
      applyStimulus($urandom_range(9, 0) < 7, 1'($urandom), 2'($urandom),
                    $urandom_range(15, 0) == 0);
    end
    idle(1);

    waitCnt = 0;
    while (sb.size() != 0 && waitCnt < 20) begin
      @(posedge iCLK);
      waitCnt++;
    end
    @(negedge iCLK);
    checkOutput("drain", YW'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
